// File: rtl/shiftreg_pkg.sv
// Shared mode encodings and parity helper for the shiftreg_tap delay line.
package shiftreg_pkg;

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_HOLD   = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_FLUSH  = 2'b11;

    // Callers zero-extend narrower data, which leaves the parity unchanged.
    localparam int PARITY_MAXW = 64;

    function automatic logic even_parity(input logic [PARITY_MAXW-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/shiftreg_stage.sv
// One delay-line stage: payload plus valid tag, with shift/rotate/flush/hold next-value mux.
module shiftreg_stage
    import shiftreg_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [PW-1:0] prev_data,
    input  logic          prev_valid,
    input  logic [PW-1:0] fb_data,
    input  logic          fb_valid,
    output logic [PW-1:0] data,
    output logic          valid
);

    logic [PW-1:0] next_data;
    logic          next_valid;

    always_comb begin
        next_data  = data;
        next_valid = valid;
        if (en) begin
            case (mode)
                MODE_SHIFT: begin
                    next_data  = prev_data;
                    next_valid = prev_valid;
                end
                MODE_ROTATE: begin
                    next_data  = fb_data;
                    next_valid = fb_valid;
                end
                MODE_FLUSH: begin
                    next_data  = '0;
                    next_valid = 1'b0;
                end
                default: begin
                    next_data  = data;
                    next_valid = valid;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            data  <= next_data;
            valid <= next_valid;
        end
    end

endmodule

// File: rtl/shiftreg_tap.sv
// Tapped WIDTH x DEPTH delay line with valid tags, occupancy count and registered tap output.
// Optional stored-parity checking with sticky parity_err when SHIFTREG_PARITY_EN is defined.
module shiftreg_tap
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int TAPW  = $clog2(DEPTH),
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [TAPW-1:0]  tap_sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CNTW-1:0]  fill_cnt,
`ifdef SHIFTREG_PARITY_EN
    output logic             parity_err,
`endif
    output logic             full
);

`ifdef SHIFTREG_PARITY_EN
    localparam int PW = WIDTH + 1;
`else
    localparam int PW = WIDTH;
`endif

    logic [PW-1:0]   stage_data  [DEPTH];
    logic            stage_valid [DEPTH];
    logic [PW-1:0]   entry_data;
    logic [TAPW-1:0] tap_idx;
    logic [PW-1:0]   tap_data;
    logic            tap_valid;

`ifdef SHIFTREG_PARITY_EN
    assign entry_data = {even_parity(PARITY_MAXW'(din)), din};
`else
    assign entry_data = din;
`endif

    // Stage 0 feeds from din on shift and from the last stage on rotate.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            shiftreg_stage #(.PW(PW)) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (en),
                .mode       (mode),
                .prev_data  (entry_data),
                .prev_valid (din_valid),
                .fb_data    (stage_data[DEPTH-1]),
                .fb_valid   (stage_valid[DEPTH-1]),
                .data       (stage_data[i]),
                .valid      (stage_valid[i])
            );
        end else begin : g_body
            shiftreg_stage #(.PW(PW)) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (en),
                .mode       (mode),
                .prev_data  (stage_data[i-1]),
                .prev_valid (stage_valid[i-1]),
                .fb_data    (stage_data[i-1]),
                .fb_valid   (stage_valid[i-1]),
                .data       (stage_data[i]),
                .valid      (stage_valid[i])
            );
        end
    end

    // Out-of-range taps (non power-of-two DEPTH) fall back to the last stage.
    always_comb begin
        tap_idx = tap_sel;
        if ({1'b0, tap_sel} >= (TAPW+1)'(DEPTH)) begin
            tap_idx = TAPW'(DEPTH - 1);
        end
        tap_data  = stage_data[tap_idx];
        tap_valid = stage_valid[tap_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout       <= tap_data[WIDTH-1:0];
            dout_valid <= tap_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (en) begin
            if (mode == MODE_SHIFT) begin
                fill_cnt <= fill_cnt + CNTW'(din_valid) - CNTW'(stage_valid[DEPTH-1]);
            end else if (mode == MODE_FLUSH) begin
                fill_cnt <= '0;
            end
        end
    end

    assign full = (fill_cnt == CNTW'(DEPTH));

`ifdef SHIFTREG_PARITY_EN
    // Stored word including its parity bit must XOR to zero when intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (en && (mode == MODE_FLUSH)) begin
            parity_err <= 1'b0;
        end else if (tap_valid && (^tap_data)) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule
